dcache_stage: RTL and testbench

- Memory stage of the in-order core and the responder to the ALU-stage request interface.
- Accepts one request per cycle from the ALU stage:
  - M-type (load/store) requests access a small direct-mapped write-back data cache.
  - R-type results pass through unchanged.
- Drives the write-back stage and the cache-to-ALU bypass.
- On a miss it stalls the ALU and performs line eviction and refill over a simple memory handshake.

---
 rtl/dcache_stage_if.sv | 52 +++++
 rtl/dcache_stage.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_stage_if.sv
// rtl/dcache_stage_if.sv - ALU request, memory handshake and write-back bundle for the memory stage
interface dcache_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int PC_WIDTH      = 32
);
    logic                     req_valid;
    logic [PC_WIDTH-1:0]      req_pc;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [DATA_WIDTH-1:0]    req_data;
    logic                     req_is_store;
    logic                     req_size;
    logic                     req_m_type;
    logic                     req_r_type;
    logic [RF_ADDR_WIDTH-1:0] req_dst_reg;
    logic                     stall_alu;

    logic                     req_mm_valid;
    logic                     req_mm_is_store;
    logic [ADDR_WIDTH-1:0]    req_mm_addr;
    logic [LINE_WIDTH-1:0]    req_mm_data;
    logic                     resp_mm_valid;
    logic [LINE_WIDTH-1:0]    resp_mm_data;

    logic                     wb_valid;
    logic [PC_WIDTH-1:0]      wb_pc;
    logic                     wb_rf_wen;
    logic [RF_ADDR_WIDTH-1:0] wb_rf_dest;
    logic [DATA_WIDTH-1:0]    wb_rf_data;
    logic [DATA_WIDTH-1:0]    cache_data_bypass;
    logic                     cache_data_bp_valid;

    // The memory stage itself
    modport slave (
        input  req_valid, req_pc, req_addr, req_data, req_is_store, req_size,
               req_m_type, req_r_type, req_dst_reg, resp_mm_valid, resp_mm_data,
        output stall_alu, req_mm_valid, req_mm_is_store, req_mm_addr, req_mm_data,
               wb_valid, wb_pc, wb_rf_wen, wb_rf_dest, wb_rf_data,
               cache_data_bypass, cache_data_bp_valid
    );

    // The surrounding pipeline and memory
    modport master (
        output req_valid, req_pc, req_addr, req_data, req_is_store, req_size,
               req_m_type, req_r_type, req_dst_reg, resp_mm_valid, resp_mm_data,
        input  stall_alu, req_mm_valid, req_mm_is_store, req_mm_addr, req_mm_data,
               wb_valid, wb_pc, wb_rf_wen, wb_rf_dest, wb_rf_data,
               cache_data_bypass, cache_data_bp_valid
    );
endinterface

// File: rtl/dcache_stage.sv
// rtl/dcache_stage.sv - memory stage with direct-mapped write-back data cache and miss FSM
module dcache_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_LINES     = 4,
    parameter int LINE_WIDTH    = 128,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int PC_WIDTH      = 32
) (
    input  logic           clock,
    input  logic           reset,
    dcache_stage_if.slave  bus
);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 4;

    typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;

    state_t state, state_next;

    logic                     s_valid;
    logic [PC_WIDTH-1:0]      s_pc;
    logic [ADDR_WIDTH-1:0]    s_addr;
    logic [DATA_WIDTH-1:0]    s_data;
    logic                     s_is_store;
    logic                     s_size;
    logic                     s_m_type;
    logic                     s_r_type;
    logic [RF_ADDR_WIDTH-1:0] s_dst;

    logic [NUM_LINES-1:0]     line_valid;
    logic [NUM_LINES-1:0]     line_dirty;
    logic [TAG_BITS-1:0]      tag_arr  [NUM_LINES];
    logic [LINE_WIDTH-1:0]    data_arr [NUM_LINES];

    logic [3:0]               s_offset;
    logic [INDEX_BITS-1:0]    s_index;
    logic [TAG_BITS-1:0]      s_tag;
    logic [LINE_WIDTH-1:0]    cur_line;
    logic [DATA_WIDTH-1:0]    load_word;
    logic [7:0]               load_byte;
    logic [DATA_WIDTH-1:0]    result;
    logic                     hit;
    logic                     stall;
    logic                     completing;
    logic                     wen_cond;
    logic                     fill_done;
    logic                     store_hit;

    logic                     mm_valid;
    logic                     mm_is_store;
    logic [ADDR_WIDTH-1:0]    mm_addr;
    logic [LINE_WIDTH-1:0]    mm_data;

    assign s_offset   = s_addr[3:0];
    assign s_index    = s_addr[INDEX_BITS+3:4];
    assign s_tag      = s_addr[ADDR_WIDTH-1:INDEX_BITS+4];
    assign cur_line   = data_arr[s_index];
    assign load_word  = cur_line[{s_offset[3:2], 5'b00000} +: DATA_WIDTH];
    assign load_byte  = cur_line[{s_offset, 3'b000} +: 8];
    assign hit        = line_valid[s_index] && (tag_arr[s_index] == s_tag);
    assign stall      = (s_valid && s_m_type && !hit) || (state != IDLE);
    assign completing = s_valid && !stall;
    assign wen_cond   = s_r_type || (s_m_type && !s_is_store);
    assign fill_done  = (state == FILL) && bus.resp_mm_valid;
    assign store_hit  = completing && s_m_type && s_is_store;

    // Stage result: loaded word/byte for memory ops, the ALU value otherwise
    always_comb begin
        result = s_data;
        if (s_m_type) begin
            if (s_size) begin
                result = load_word;
            end else begin
                result = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            end
        end
    end

    // Stage register: holds the request while a miss is serviced
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_valid    <= 1'b0;
            s_pc       <= '0;
            s_addr     <= '0;
            s_data     <= '0;
            s_is_store <= 1'b0;
            s_size     <= 1'b0;
            s_m_type   <= 1'b0;
            s_r_type   <= 1'b0;
            s_dst      <= '0;
        end else if (!stall) begin
            s_valid    <= bus.req_valid;
            s_pc       <= bus.req_pc;
            s_addr     <= bus.req_addr;
            s_data     <= bus.req_data;
            s_is_store <= bus.req_is_store;
            s_size     <= bus.req_size;
            s_m_type   <= bus.req_m_type;
            s_r_type   <= bus.req_r_type;
            s_dst      <= bus.req_dst_reg;
        end
    end

    // Line status bits: set valid/clean on fill, dirty on a store hit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_valid <= '0;
            line_dirty <= '0;
        end else if (fill_done) begin
            line_valid[s_index] <= 1'b1;
            line_dirty[s_index] <= 1'b0;
        end else if (store_hit) begin
            line_dirty[s_index] <= 1'b1;
        end
    end

    // Tag and line storage: refill installs a line, store hits merge a word or byte
    always_ff @(posedge clock) begin
        if (fill_done) begin
            tag_arr[s_index]  <= s_tag;
            data_arr[s_index] <= bus.resp_mm_data;
        end else if (store_hit) begin
            if (s_size) begin
                data_arr[s_index][{s_offset[3:2], 5'b00000} +: DATA_WIDTH] <= s_data;
            end else begin
                data_arr[s_index][{s_offset, 3'b000} +: 8] <= s_data[7:0];
            end
        end
    end

    // Miss FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Miss FSM next state and memory request; request fields derive from held stage state
    always_comb begin
        state_next  = state;
        mm_valid    = 1'b0;
        mm_is_store = 1'b0;
        mm_addr     = '0;
        mm_data     = '0;
        case (state)
            IDLE: begin
                if (s_valid && s_m_type && !hit) begin
                    if (line_valid[s_index] && line_dirty[s_index]) begin
                        state_next = EVICT;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            EVICT: begin
                mm_valid    = 1'b1;
                mm_is_store = 1'b1;
                mm_addr     = {tag_arr[s_index], s_index, 4'b0000};
                mm_data     = cur_line;
                if (bus.resp_mm_valid) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mm_valid = 1'b1;
                mm_addr  = {s_addr[ADDR_WIDTH-1:4], 4'b0000};
                if (bus.resp_mm_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write-back register: one pulse per completed stage op
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.wb_valid   <= 1'b0;
            bus.wb_rf_wen  <= 1'b0;
            bus.wb_pc      <= '0;
            bus.wb_rf_dest <= '0;
            bus.wb_rf_data <= '0;
        end else begin
            bus.wb_valid  <= completing;
            bus.wb_rf_wen <= completing && wen_cond;
            if (completing) begin
                bus.wb_pc      <= s_pc;
                bus.wb_rf_dest <= s_dst;
                bus.wb_rf_data <= result;
            end
        end
    end

    assign bus.stall_alu           = stall;
    assign bus.req_mm_valid        = mm_valid;
    assign bus.req_mm_is_store     = mm_is_store;
    assign bus.req_mm_addr         = mm_addr;
    assign bus.req_mm_data         = mm_data;
    assign bus.cache_data_bypass   = completing ? result : '0;
    assign bus.cache_data_bp_valid = completing && wen_cond;
endmodule

// File: tb/tb_dcache_stage.sv
// tb/tb_dcache_stage.sv - directed self-checking bench for dcache_stage
module tb_dcache_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;

    dcache_stage_if bus ();

    dcache_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errs   = 0;

    int mem_delay = 0;
    int wait_cnt  = 0;
    int fill_cnt  = 0;
    int evict_cnt = 0;
    int unstable  = 0;
    logic [31:0]  held_addr       = '0;
    logic [31:0]  last_fill_addr  = '0;
    logic [31:0]  last_evict_addr = '0;
    logic [127:0] last_evict_data = '0;
    logic [127:0] mem [logic [31:0]];

    int          wb_count  = 0;
    logic        last_wen  = 1'b0;
    logic [4:0]  last_dest = '0;
    logic [31:0] last_data = '0;
    logic [31:0] last_pc   = '0;
    logic [31:0] wb_log [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.stall_alu, bus.req_mm_valid, bus.req_mm_is_store, |bus.req_mm_addr,
                |bus.req_mm_data, bus.wb_valid, bus.wb_rf_wen, |bus.wb_pc, |bus.wb_rf_dest,
                |bus.wb_rf_data, |bus.cache_data_bypass, bus.cache_data_bp_valid};
    endfunction

    // Memory responder: acks after mem_delay extra cycles, logs fills and writebacks
    initial begin
        bus.resp_mm_valid = 1'b0;
        bus.resp_mm_data  = '0;
        forever begin
            @(negedge clock);
            bus.resp_mm_valid = 1'b0;
            if (reset || !bus.req_mm_valid) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) held_addr = bus.req_mm_addr;
                else if (bus.req_mm_addr !== held_addr) unstable++;
                if (wait_cnt >= mem_delay) begin
                    wait_cnt = 0;
                    bus.resp_mm_valid = 1'b1;
                    if (bus.req_mm_is_store) begin
                        evict_cnt++;
                        last_evict_addr = bus.req_mm_addr;
                        last_evict_data = bus.req_mm_data;
                        mem[bus.req_mm_addr] = bus.req_mm_data;
                        bus.resp_mm_data = '0;
                    end else begin
                        fill_cnt++;
                        last_fill_addr = bus.req_mm_addr;
                        bus.resp_mm_data = mem_line(bus.req_mm_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Write-back monitor
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (bus.wb_valid) begin
                wb_count++;
                last_wen  = bus.wb_rf_wen;
                last_dest = bus.wb_rf_dest;
                last_data = bus.wb_rf_data;
                last_pc   = bus.wb_pc;
                wb_log.push_back(bus.wb_rf_data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after the capture edge with req_valid still high
    task automatic drive_capture(input logic [31:0] pc, addr, data, input logic st, sz, m, r,
                                 input logic [4:0] dst);
        int n;
        bus.req_pc       = pc;
        bus.req_addr     = addr;
        bus.req_data     = data;
        bus.req_is_store = st;
        bus.req_size     = sz;
        bus.req_m_type   = m;
        bus.req_r_type   = r;
        bus.req_dst_reg  = dst;
        bus.req_valid    = 1'b1;
        n = 0;
        while (bus.stall_alu && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("capture_timeout", 128'(n), 128'd0);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic [31:0] pc, addr, data, input logic st, sz, m, r,
                         input logic [4:0] dst, output int lat, output int stall_cyc,
                         output logic bp_v0, output logic [31:0] bp0);
        int base;
        @(negedge clock);
        drive_capture(pc, addr, data, st, sz, m, r, dst);
        bus.req_valid = 1'b0;
        bp_v0 = bus.cache_data_bp_valid;
        bp0   = bus.cache_data_bypass;
        base  = wb_count;
        lat = 0;
        stall_cyc = 0;
        while (wb_count == base && lat < 100) begin
            if (bus.stall_alu) stall_cyc++;
            @(negedge clock);
            lat++;
        end
        if (lat >= 100) check("wb_timeout", 128'(lat), 128'd0);
    endtask

    int          lat, sc, f0, e0, w0, u0, n;
    logic        bpv;
    logic [31:0] bpd;

    initial begin
        bus.req_valid = 1'b0; bus.req_pc = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.req_is_store = 1'b0; bus.req_size = 1'b0; bus.req_m_type = 1'b0;
        bus.req_r_type = 1'b0; bus.req_dst_reg = '0;
        mem[32'h40] = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hDEADBEEF, 32'hA0A0A0A0};

        repeat (3) @(negedge clock);
        check("reset_outputs", 128'(outs()), 128'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", 128'(outs()), 128'd0);

        // Cold word load, clean miss
        f0 = fill_cnt; e0 = evict_cnt;
        issue(32'h100, 32'h44, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, lat, sc, bpv, bpd);
        check("t1_fills", 128'(fill_cnt - f0), 128'd1);
        check("t1_evicts", 128'(evict_cnt - e0), 128'd0);
        check("t1_fill_addr", 128'(last_fill_addr), 128'h40);
        check("t1_data", 128'(last_data), 128'hDEADBEEF);
        check("t1_wen", 128'(last_wen), 128'd1);
        check("t1_dest", 128'(last_dest), 128'd5);
        check("t1_pc", 128'(last_pc), 128'h100);
        check("t1_latency", 128'(lat), 128'd3);
        check("t1_stall_cycles", 128'(sc), 128'd2);

        // Store word hit, then byte loads from the merged line
        f0 = fill_cnt; e0 = evict_cnt;
        issue(32'h104, 32'h44, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, lat, sc, bpv, bpd);
        check("t2_store_lat", 128'(lat), 128'd1);
        check("t2_store_wen", 128'(last_wen), 128'd0);
        check("t2_store_bp", 128'(bpv), 128'd0);
        issue(32'h108, 32'h45, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, lat, sc, bpv, bpd);
        check("t2_byte45", 128'(last_data), 128'h56);
        check("t2_byte45_bypass", 128'(bpd), 128'h56);
        check("t2_byte45_lat", 128'(lat), 128'd1);
        issue(32'h10C, 32'h47, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, lat, sc, bpv, bpd);
        check("t2_byte47", 128'(last_data), 128'h12);
        check("t2_no_traffic", 128'((fill_cnt - f0) + (evict_cnt - e0)), 128'd0);

        // Dirty eviction on a conflicting tag
        f0 = fill_cnt; e0 = evict_cnt;
        issue(32'h110, 32'h84, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, lat, sc, bpv, bpd);
        check("t3_evicts", 128'(evict_cnt - e0), 128'd1);
        check("t3_evict_addr", 128'(last_evict_addr), 128'h40);
        check("t3_evict_line", last_evict_data,
              {32'hA3A3A3A3, 32'hA2A2A2A2, 32'h12345678, 32'hA0A0A0A0});
        check("t3_fills", 128'(fill_cnt - f0), 128'd1);
        check("t3_fill_addr", 128'(last_fill_addr), 128'h80);
        check("t3_data", 128'(last_data), 128'h84);
        check("t3_latency", 128'(lat), 128'd4);
        check("t3_stall_cycles", 128'(sc), 128'd3);

        // R-type passthrough and bypass
        issue(32'h114, 32'h0, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, lat, sc, bpv, bpd);
        check("t4_bp_valid", 128'(bpv), 128'd1);
        check("t4_bypass", 128'(bpd), 128'h7);
        check("t4_latency", 128'(lat), 128'd1);
        check("t4_stall", 128'(sc), 128'd0);
        check("t4_dest", 128'(last_dest), 128'd3);
        check("t4_data", 128'(last_data), 128'h7);
        check("t4_wen", 128'(last_wen), 128'd1);

        // Branch: retires without RF write
        issue(32'h200, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, lat, sc, bpv, bpd);
        check("br_latency", 128'(lat), 128'd1);
        check("br_wen", 128'(last_wen), 128'd0);
        check("br_bp_valid", 128'(bpv), 128'd0);
        check("br_pc", 128'(last_pc), 128'h200);

        // Delayed fill acknowledge
        mem_delay = 5;
        f0 = fill_cnt; u0 = unstable; w0 = wb_count;
        issue(32'h300, 32'h110, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, lat, sc, bpv, bpd);
        repeat (3) @(negedge clock);
        check("t5_latency", 128'(lat), 128'd8);
        check("t5_stall_cycles", 128'(sc), 128'd7);
        check("t5_addr_stable", 128'(unstable - u0), 128'd0);
        check("t5_fill_addr", 128'(last_fill_addr), 128'h110);
        check("t5_fills", 128'(fill_cnt - f0), 128'd1);
        check("t5_data", 128'(last_data), 128'h110);
        check("t5_wb_pulses", 128'(wb_count - w0), 128'd1);
        mem_delay = 0;

        // Back-to-back requests to one line while its miss is in progress
        f0 = fill_cnt; w0 = wb_count; n = wb_log.size();
        @(negedge clock);
        drive_capture(32'h400, 32'h300, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10);
        drive_capture(32'h404, 32'h304, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && wb_count - w0 < 2; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("b2b_fills", 128'(fill_cnt - f0), 128'd1);
        check("b2b_wb_pulses", 128'(wb_count - w0), 128'd2);
        if (wb_log.size() >= n + 2) begin
            check("b2b_first", 128'(wb_log[n]), 128'h300);
            check("b2b_second", 128'(wb_log[n+1]), 128'h304);
        end else begin
            check("b2b_log_size", 128'(wb_log.size() - n), 128'd2);
        end

        // Reset in the middle of a fill
        mem_delay = 10;
        @(negedge clock);
        drive_capture(32'h500, 32'h210, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.req_mm_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t6_fill_started", 128'(bus.req_mm_valid), 128'd1);
        repeat (2) @(negedge clock);
        w0 = wb_count;
        #3 reset = 1'b1;
        #1 check("t6_async_reset_outputs", 128'(outs()), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        mem_delay = 0;
        repeat (3) @(negedge clock);
        check("t6_dropped", 128'(wb_count - w0), 128'd0);
        f0 = fill_cnt;
        issue(32'h504, 32'h210, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12, lat, sc, bpv, bpd);
        check("t6_refill", 128'(fill_cnt - f0), 128'd1);
        check("t6_fill_addr", 128'(last_fill_addr), 128'h210);
        check("t6_data", 128'(last_data), 128'h210);
        check("t6_latency", 128'(lat), 128'd3);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
